// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg: shared line-state and timing constants for the USB full-speed RX path.
package usb_rx_pkg;
    localparam logic USB_IDLE_J       = 1'b1;
    localparam int   BITS_PER_BYTE    = 8;
    localparam int   DEF_CLKS_PER_BIT = 8;
    localparam int   DEF_SAMPLE_PHASE = 3;
    localparam int   DEF_STUFF_LIMIT  = 6;
endpackage

// File: rtl/usb_rx_edge_detect.sv
// usb_rx_edge_detect: flags any transition of the synchronised D+ line.
// The previous-line register tracks the line every cycle, independent of rcving.
module usb_rx_edge_detect
    import usb_rx_pkg::*;
(
    input  logic clk,
    input  logic n_rst,
    input  logic line,
    output logic line_edge
);
    logic prev_line_q, prev_line_d;

    always_comb prev_line_d = line;

    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) prev_line_q <= USB_IDLE_J;
        else        prev_line_q <= prev_line_d;

    assign line_edge = line != prev_line_q;
endmodule

// File: rtl/usb_rx_bit_timer.sv
// usb_rx_bit_timer: edge-resynced mid-bit sampler with NRZI decode and bit unstuffing.
// Emits shift_enable/d_orig to the byte shift register and byte_received/stuff_err to the RCU.
module usb_rx_bit_timer
    import usb_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int SAMPLE_PHASE = DEF_SAMPLE_PHASE,
    parameter int STUFF_LIMIT  = DEF_STUFF_LIMIT
) (
    input  logic clk,
    input  logic n_rst,
    input  logic d_plus_sync,
    input  logic rcving,
    output logic shift_enable,
    output logic d_orig,
    output logic byte_received,
    output logic stuff_err
);
    localparam int PW = $clog2(CLKS_PER_BIT);
    localparam int OW = $clog2(STUFF_LIMIT + 1);
    localparam int BW = $clog2(BITS_PER_BYTE);

    logic          line_edge;
    logic [PW-1:0] phase_q, phase_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [OW-1:0] ones_cnt_q, ones_cnt_d;
    logic          prev_sample_q, prev_sample_d;
    logic          shift_enable_q, shift_enable_d;
    logic          d_orig_q, d_orig_d;
    logic          byte_received_q, byte_received_d;
    logic          stuff_err_q, stuff_err_d;
    logic          sample, decoded, stuffed;

    usb_rx_edge_detect u_edge (
        .clk       (clk),
        .n_rst     (n_rst),
        .line      (d_plus_sync),
        .line_edge (line_edge)
    );

    // An edge wins over the sample phase: it restarts the bit, so that cycle is not a sample.
    assign sample  = rcving && !line_edge && phase_q == PW'(SAMPLE_PHASE);
    assign decoded = d_plus_sync == prev_sample_q;
    assign stuffed = ones_cnt_q == OW'(STUFF_LIMIT);

    always_comb begin
        phase_d         = line_edge ? PW'(1) : (phase_q == PW'(CLKS_PER_BIT - 1)) ? '0 : phase_q + 1'b1;
        bit_cnt_d       = bit_cnt_q;
        ones_cnt_d      = ones_cnt_q;
        prev_sample_d   = prev_sample_q;
        shift_enable_d  = 1'b0;
        d_orig_d        = d_orig_q;
        stuff_err_d     = 1'b0;
        // bit_cnt has already wrapped to 0 when the 8th data bit is on shift_enable
        byte_received_d = shift_enable_q && bit_cnt_q == '0;
        if (!rcving) begin
            phase_d         = '0;
            bit_cnt_d       = '0;
            ones_cnt_d      = '0;
            prev_sample_d   = USB_IDLE_J;
            byte_received_d = 1'b0;
        end else if (sample) begin
            prev_sample_d = d_plus_sync;
            if (stuffed) begin
                ones_cnt_d  = '0;
                stuff_err_d = decoded;
            end else begin
                shift_enable_d = 1'b1;
                d_orig_d       = decoded;
                bit_cnt_d      = bit_cnt_q + 1'b1;
                ones_cnt_d     = decoded ? ones_cnt_q + 1'b1 : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) begin
            phase_q         <= '0;
            bit_cnt_q       <= '0;
            ones_cnt_q      <= '0;
            prev_sample_q   <= USB_IDLE_J;
            shift_enable_q  <= 1'b0;
            d_orig_q        <= USB_IDLE_J;
            byte_received_q <= 1'b0;
            stuff_err_q     <= 1'b0;
        end else begin
            phase_q         <= phase_d;
            bit_cnt_q       <= bit_cnt_d;
            ones_cnt_q      <= ones_cnt_d;
            prev_sample_q   <= prev_sample_d;
            shift_enable_q  <= shift_enable_d;
            d_orig_q        <= d_orig_d;
            byte_received_q <= byte_received_d;
            stuff_err_q     <= stuff_err_d;
        end

    assign shift_enable  = shift_enable_q;
    assign d_orig        = d_orig_q;
    assign byte_received = byte_received_q;
    assign stuff_err     = stuff_err_q;
endmodule

// File: tb/tb_usb_rx_bit_timer.sv
// tb_usb_rx_bit_timer: packet-level model encodes data with bit stuffing and NRZI,
// predicts pulse times from bit start times, and compares against recorded DUT pulses.
module tb_usb_rx_bit_timer;
    import usb_rx_pkg::*;

    logic clk = 1'b0, n_rst = 1'b0, d_plus_sync = 1'b1, rcving = 1'b0;
    logic shift_enable, d_orig, byte_received, stuff_err;

    usb_rx_bit_timer dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .d_plus_sync   (d_plus_sync),
        .rcving        (rcving),
        .shift_enable  (shift_enable),
        .d_orig        (d_orig),
        .byte_received (byte_received),
        .stuff_err     (stuff_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    int se_t[$], br_t[$], er_t[$], x_se_t[$], x_br_t[$], x_er_t[$];
    bit se_v[$], x_se_v[$];

    logic line_lv;
    int   anchor, kbits, run, nbits;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) if (n_rst) begin
        if (shift_enable) begin se_t.push_back(cyc); se_v.push_back(d_orig); end
        if (byte_received) br_t.push_back(cyc);
        if (stuff_err) er_t.push_back(cyc);
        if (shift_enable || byte_received || stuff_err)
            chk("one_pulse", $countones({shift_enable, byte_received, stuff_err}), 1);
    end

    task automatic clear_q();
        se_t.delete(); se_v.delete(); br_t.delete(); er_t.delete();
        x_se_t.delete(); x_se_v.delete(); x_br_t.delete(); x_er_t.delete();
    endtask

    task automatic verify(input string tag);
        chk({tag, "_se_n"}, se_t.size(), x_se_t.size());
        chk({tag, "_br_n"}, br_t.size(), x_br_t.size());
        chk({tag, "_err_n"}, er_t.size(), x_er_t.size());
        for (int i = 0; i < se_t.size() && i < x_se_t.size(); i++) begin
            chk({tag, "_se_t"}, se_t[i], x_se_t[i]);
            chk({tag, "_se_v"}, int'(se_v[i]), int'(x_se_v[i]));
        end
        for (int i = 0; i < br_t.size() && i < x_br_t.size(); i++) chk({tag, "_br_t"}, br_t[i], x_br_t[i]);
        for (int i = 0; i < er_t.size() && i < x_er_t.size(); i++) chk({tag, "_err_t"}, er_t[i], x_er_t[i]);
        clear_q();
    endtask

    // kind: 0 data bit, 1 correct stuffed bit, 2 stuffed position with no transition
    task automatic send(input bit v, input int kind, input int dur);
        logic nl;
        nl = (kind == 2) ? line_lv : (kind == 1) ? ~line_lv : (v ? line_lv : ~line_lv);
        d_plus_sync = nl;
        if (nl != line_lv) begin anchor = cyc; kbits = 0; end
        else kbits++;
        line_lv = nl;
        if (kind == 0) begin
            x_se_t.push_back(anchor + 4 + 8 * kbits);
            x_se_v.push_back(v);
            nbits++;
            if (nbits % 8 == 0) x_br_t.push_back(anchor + 5 + 8 * kbits);
        end
        if (kind == 2) x_er_t.push_back(anchor + 4 + 8 * kbits);
        repeat (dur) @(negedge clk);
    endtask

    task automatic send_data(input bit v, input int dur);
        send(v, 0, dur);
        run = v ? run + 1 : 0;
        if (run == 6) begin send(1'b0, 1, 8); run = 0; end
    endtask

    // sidx: index of the bit stretched to 9 clks; the following bit shrinks to 7
    task automatic send_byte(input logic [7:0] b, input int sidx);
        for (int i = 0; i < 8; i++) send_data(b[i], i == sidx ? 9 : i == sidx + 1 ? 7 : 8);
    endtask

    task automatic start_pkt(input int sidx);
        rcving = 1'b1; line_lv = USB_IDLE_J; run = 0; nbits = 0;
        send_byte(8'h80, sidx);
    endtask

    task automatic end_pkt();
        rcving = 1'b0; d_plus_sync = USB_IDLE_J; line_lv = USB_IDLE_J;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        logic [7:0] b;
        int nb;
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        repeat (4) @(negedge clk);
        // reset asserted mid-stream while a pulse is live
        rcving = 1'b1; d_plus_sync = 1'b0;
        for (int i = 0; i < 20 && shift_enable !== 1'b1; i++) begin @(posedge clk); #1; end
        chk("rst_pre_pulse", shift_enable, 1);
        n_rst = 1'b0; #1;
        chk("rst_se", shift_enable, 0);
        chk("rst_dorig", d_orig, 1);
        chk("rst_br", byte_received, 0);
        chk("rst_err", stuff_err, 0);
        @(negedge clk); rcving = 1'b0; d_plus_sync = 1'b1;
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        clear_q();
        for (int i = 0; i < 40; i++) begin d_plus_sync = 1'($urandom_range(0, 1)); @(negedge clk); end
        d_plus_sync = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_dorig", d_orig, 1);
        verify("idle");
        // SYNC only
        start_pkt(-1); end_pkt(); verify("sync");
        // run of ones with correct stuffing
        start_pkt(-1); send_byte(8'hFE, -1); send_byte(8'hFF, -1); end_pkt(); verify("stuff_ok");
        // missing stuffed transition
        start_pkt(-1);
        send(1'b0, 0, 8);
        for (int i = 0; i < 6; i++) send(1'b1, 0, 8);
        send(1'b1, 2, 8);
        send(1'b1, 0, 8);
        end_pkt(); verify("stuff_err");
        // stretched/shrunk bits inside SYNC
        start_pkt(2); send_byte(8'h5A, 4); end_pkt(); verify("jitter");
        // drop mid-byte then restart
        start_pkt(-1);
        for (int i = 0; i < 5; i++) send_data(1'($urandom_range(0, 1)), 8);
        end_pkt();
        start_pkt(-1); send_byte(8'h3C, -1); end_pkt(); verify("drop");
        // random packets, biased toward long runs of ones
        for (int p = 0; p < 6; p++) begin
            nb = $urandom_range(1, 3);
            start_pkt(-1);
            for (int j = 0; j < nb; j++) begin
                b = 8'($urandom);
                if ($urandom_range(0, 1) == 1) b = b | 8'($urandom);
                send_byte(b, -1);
            end
            end_pkt(); verify("rand");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
